fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 1024x16 program/data memory (combinational read, synchronous write).
- Owns the program counter, drives the memory read address, and captures the returned word into a 2-entry buffer.
- Presents instructions to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) and a sticky halt.

Parameters:
- ADDR_W, 10, memory address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_addr  output  ADDR_W  read address to memory; always equals current PC.
- mem_data  input  DATA_W  memory read data, valid in the same cycle as mem_addr.
- ir  output  DATA_W  instruction at buffer head.
- ir_pc  output  ADDR_W  address of the word on ir.
- ir_valid  output  1  buffer head holds a valid instruction.
- ir_ready  input  1  decode accepts ir this cycle.
- redirect  input  1  load redirect_pc and flush the buffer.
- redirect_pc  input  ADDR_W  new PC for a redirect.
- halt_req  input  1  stop fetching (sticky).
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, buffer count=0, ir_valid=0, ir=0, ir_pc=0, halted=0, state=RUN.
- mem_addr = pc combinationally at all times; the fetch unit never writes memory.
- pop = ir_valid & ir_ready.
- push = (state==RUN) & ~redirect & (count<2 | pop).
- On push, {mem_data, pc} is written at the buffer tail and pc <= pc+1 mod 2^ADDR_W (1023 -> 0).
- Latency: a word addressed in cycle N is visible on ir with ir_valid=1 in cycle N+1 if the buffer was empty.
- Buffer: 2-entry FIFO, head drives ir/ir_pc.
  - count+1 on push only, count-1 on pop only, unchanged on push+pop.
  - ir_valid = (count!=0).
  - ir/ir_pc hold their value while ir_valid & ~ir_ready.
- Full (count==2) with no pop: no push, pc holds.
- Full with pop: push and pop occur in the same cycle, so throughput stays at 1 word/cycle.
- Redirect has priority over all other events:
  - Cycle N: a pop in this cycle is honoured, since the head word is older than the branch.
  - End of cycle N: buffer flushed (count=0), pc <= redirect_pc, state <= RUN (clears HALT).
  - No push in cycle N.
  - N+1: mem_addr=redirect_pc, ir_valid=0.
  - N+2: ir_valid=1, ir_pc=redirect_pc.
- FSM:
  - RUN -> HALT when halt_req=1 and redirect=0. The push in that same cycle is suppressed, so pc holds.
  - HALT: no pushes; buffer continues to drain via pop; halted=1.
  - HALT -> RUN only on redirect. halt_req deasserting does not leave HALT.
  - halt_req and redirect asserted together: redirect wins and state = RUN.
- Reset mid-operation: all state returns to reset values immediately; any buffered words are discarded.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Extra output fetch_count [15:0], reset 0.
  - Increments on every push and saturates at 16'hFFFF.
  - Not cleared by redirect.
  - Extra output redirect_count [7:0], reset 0, increments on each redirect cycle and saturates at 8'hFF.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset, memory[0..3]=16'hA000..A003, ir_ready=1 -> ir_valid rises the cycle after rst falls; ir/ir_pc = A000/0, A001/1, A002/2, A003/3 on consecutive cycles.
- ir_ready=0 for 5 cycles after the first word -> count reaches 2, pc holds at 2, ir stays A000/0. On ir_ready=1, the words follow in order without gaps or duplicates.
- redirect=1 with redirect_pc=10'h200 while count==2 and pop=1 -> the popped word is accepted. Next cycle ir_valid=0 and mem_addr=10'h200. The cycle after, ir_pc=10'h200 and ir=mem[10'h200].
- Redirect to 10'h3FE, ir_ready=1 -> ir_pc sequence is 3FE, 3FF, 000, 001 (wrap).
- halt_req pulse for 1 cycle with 2 words buffered -> halted=1, both words still drain, then ir_valid=0 and pc is frozen. Redirect to 10'h010 -> halted=0 and fetch resumes at 10'h010.
- FETCH_STATS_EN defined: 100 fetches plus 3 redirects -> fetch_count equals the number of pushes (checked against bench model), redirect_count=3. Reset clears both counters.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: PC, memory read address, 2-entry instruction buffer, redirect and sticky halt.
// Optional FETCH_STATS_EN adds fetch_count / redirect_count statistics outputs.
module fetch_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [7:0]        redirect_count
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d0_nxt;
    logic [DATA_W-1:0] d1_nxt;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a0_nxt;
    logic [ADDR_W-1:0] a1_nxt;
    logic              pop;
    logic              push;

    assign mem_addr = pc;
    assign ir       = d0;
    assign ir_pc    = a0;
    assign ir_valid = (count != 2'd0);
    assign halted   = (state == HALT);

    assign pop  = ir_valid & ir_ready;
    // The cycle that enters HALT must not fetch, so halt_req blocks the push.
    assign push = (state == RUN) & ~redirect & ~halt_req
                & ((count != 2'd2) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    state_nxt = RUN;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (redirect) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = redirect_pc;
        end else if (push) begin
            pc_nxt = pc + ADDR_W'(1);
        end
    end

    // Entry 0 is always the head; entry 1 shifts down on pop.
    always_comb begin
        count_nxt = count;
        d0_nxt    = d0;
        d1_nxt    = d1;
        a0_nxt    = a0;
        a1_nxt    = a1;
        if (redirect) begin
            count_nxt = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        d0_nxt = mem_data;
                        a0_nxt = pc;
                    end else begin
                        d1_nxt = mem_data;
                        a1_nxt = pc;
                    end
                    count_nxt = count + 2'd1;
                end
                2'b01: begin
                    d0_nxt    = d1;
                    a0_nxt    = a1;
                    count_nxt = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        d0_nxt = mem_data;
                        a0_nxt = pc;
                    end else begin
                        d0_nxt = d1;
                        a0_nxt = a1;
                        d1_nxt = mem_data;
                        a1_nxt = pc;
                    end
                end
                default: begin
                    count_nxt = count;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            d0    <= '0;
            d1    <= '0;
            a0    <= '0;
            a1    <= '0;
        end else begin
            pc    <= pc_nxt;
            count <= count_nxt;
            d0    <= d0_nxt;
            d1    <= d1_nxt;
            a0    <= a0_nxt;
            a1    <= a1_nxt;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count    <= 16'd0;
            redirect_count <= 8'd0;
        end else begin
            if (push && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect && (redirect_count != 8'hFF)) begin
                redirect_count <= redirect_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a behavioural 1024x16 memory.
// Build with FETCH_STATS_EN defined to also exercise the statistics counters.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [9:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [7:0]  redirect_count;
`endif

    logic [15:0] mem [1024];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rdy;
        logic       redir;
        logic       halt;
        logic [9:0] rpc;
        logic       v;
        logic [9:0] ipc;
        logic [9:0] ma;
        logic       h;
    } vec_t;

    vec_t tv [29];

    fetch_unit #(
        .ADDR_W  (10),
        .DATA_W  (16),
        .RESET_PC(10'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .halted     (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`endif
    );

    assign mem_data = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int exp_f;
        for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);

        //        rdy redir halt rpc      v  ipc     ma      h
        tv[0]  = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h000, 0};
        tv[1]  = '{0, 0, 0, 10'h000, 1, 10'h000, 10'h001, 0};
        tv[2]  = '{0, 0, 0, 10'h000, 1, 10'h000, 10'h002, 0};
        tv[3]  = '{0, 0, 0, 10'h000, 1, 10'h000, 10'h002, 0};
        tv[4]  = '{0, 0, 0, 10'h000, 1, 10'h000, 10'h002, 0};
        tv[5]  = '{0, 0, 0, 10'h000, 1, 10'h000, 10'h002, 0};
        tv[6]  = '{1, 0, 0, 10'h000, 1, 10'h000, 10'h002, 0};
        tv[7]  = '{1, 0, 0, 10'h000, 1, 10'h001, 10'h003, 0};
        tv[8]  = '{1, 0, 0, 10'h000, 1, 10'h002, 10'h004, 0};
        tv[9]  = '{1, 1, 0, 10'h200, 1, 10'h003, 10'h005, 0};
        tv[10] = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h200, 0};
        tv[11] = '{1, 0, 0, 10'h000, 1, 10'h200, 10'h201, 0};
        tv[12] = '{1, 1, 0, 10'h3FE, 1, 10'h201, 10'h202, 0};
        tv[13] = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h3FE, 0};
        tv[14] = '{1, 0, 0, 10'h000, 1, 10'h3FE, 10'h3FF, 0};
        tv[15] = '{1, 0, 0, 10'h000, 1, 10'h3FF, 10'h000, 0};
        tv[16] = '{1, 0, 0, 10'h000, 1, 10'h000, 10'h001, 0};
        tv[17] = '{0, 0, 0, 10'h000, 1, 10'h001, 10'h002, 0};
        tv[18] = '{0, 0, 1, 10'h000, 1, 10'h001, 10'h003, 0};
        tv[19] = '{1, 0, 0, 10'h000, 1, 10'h001, 10'h003, 1};
        tv[20] = '{1, 0, 0, 10'h000, 1, 10'h002, 10'h003, 1};
        tv[21] = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h003, 1};
        tv[22] = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h003, 1};
        tv[23] = '{1, 1, 0, 10'h010, 0, 10'h000, 10'h003, 1};
        tv[24] = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h010, 0};
        tv[25] = '{1, 0, 0, 10'h000, 1, 10'h010, 10'h011, 0};
        tv[26] = '{1, 1, 1, 10'h020, 1, 10'h011, 10'h012, 0};
        tv[27] = '{1, 0, 0, 10'h000, 0, 10'h000, 10'h020, 0};
        tv[28] = '{1, 0, 0, 10'h000, 1, 10'h020, 10'h021, 0};

        rst         = 1'b1;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 10'h000;
        halt_req    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ir_pc", 32'(ir_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 29; i++) begin
            ir_ready    = tv[i].rdy;
            redirect    = tv[i].redir;
            halt_req    = tv[i].halt;
            redirect_pc = tv[i].rpc;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(ir_valid), 32'(tv[i].v));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].ma));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tv[i].h));
            if (tv[i].v) begin
                chk($sformatf("v%0d_ir_pc", i), 32'(ir_pc), 32'(tv[i].ipc));
                chk($sformatf("v%0d_ir", i), 32'(ir), 32'(16'hA000 + 16'(tv[i].ipc)));
            end
            @(negedge clk);
        end

        // Asynchronous reset mid-operation, between clock edges.
        ir_ready = 1'b0;
        redirect = 1'b0;
        halt_req = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(ir_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ir_valid), 32'd0);
        chk("arst_ir", 32'(ir), 32'h0);
        chk("arst_ir_pc", 32'(ir_pc), 32'h0);
        chk("arst_mem_addr", 32'(mem_addr), 32'h0);
        chk("arst_halted", 32'(halted), 32'd0);

        @(negedge clk);
        rst      = 1'b0;
        ir_ready = 1'b1;
        #1;
        chk("post_rst_valid0", 32'(ir_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_valid1", 32'(ir_valid), 32'd1);
        chk("post_rst_ir", 32'(ir), 32'hA000);
        chk("post_rst_mem_addr", 32'(mem_addr), 32'h001);

`ifdef FETCH_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("stat_rst_fetch", 32'(fetch_count), 32'd0);
        chk("stat_rst_redir", 32'(redirect_count), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        ir_ready = 1'b1;
        exp_f    = 0;
        repeat (100) begin
            exp_f++;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            redirect    = 1'b1;
            redirect_pc = 10'(10'h100 * k);
            @(negedge clk);
            redirect = 1'b0;
            exp_f++;
            @(negedge clk);
        end
        #1;
        chk("stat_fetch", 32'(fetch_count), 32'(exp_f));
        chk("stat_redir", 32'(redirect_count), 32'd3);
        rst = 1'b1;
        #1;
        chk("stat_clr_fetch", 32'(fetch_count), 32'd0);
        chk("stat_clr_redir", 32'(redirect_count), 32'd0);
        rst = 1'b0;
`else
        exp_f = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
